// File: rtl/video_pkg.sv
// video_pkg: shared video-memory geometry, store-size encoding and writer FSM states
package video_pkg;
    localparam int VM_COLS  = 80;
    localparam int VM_ROWS  = 30;
    localparam int VM_WORDS = 600;
    localparam int VM_BYTES = 2400;
    typedef enum logic [1:0] {VM_BYTE = 2'b00, VM_HALF = 2'b01, VM_WORD = 2'b10} vm_size_t;
    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} vmw_state_t;
endpackage

// File: rtl/vmw_lane_decode.sv
// vmw_lane_decode: combinational CPU store -> word address, lane data, byte enables, error
//   addr[11:0] byte address, size[1:0] store size, data[31:0] right-aligned store data
//   word_addr[9:0], lane_data[31:0] replicated data, we[3:0] byte enables (0 on error), err
module vmw_lane_decode
    import video_pkg::*;
(
    input  logic [11:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [9:0]  word_addr,
    output logic [31:0] lane_data,
    output logic [3:0]  we,
    output logic        err
);
    logic [1:0] off;
    logic [3:0] raw_we;
    assign off       = addr[1:0];
    assign word_addr = addr[11:2];
    assign lane_data = size == VM_BYTE ? {4{data[7:0]}} : size == VM_HALF ? {2{data[15:0]}} : data;
    assign raw_we    = size == VM_BYTE ? 4'b0001 << off : size == VM_HALF ? 4'b0011 << off : 4'b1111;
    assign err       = addr >= 12'(VM_BYTES) || size == 2'b11 ||
                       (size == VM_HALF && off[0]) || (size == VM_WORD && off != 2'b00);
    assign we        = err ? 4'b0000 : raw_we;
endmodule

// File: rtl/video_memory_writer.sv
// video_memory_writer: arbitrates CPU stores and a fill engine onto the video-memory write port
//   clk, rst_n (async active-low); cpu_valid/cpu_ready/cpu_addr/cpu_size/cpu_data store port,
//   cpu_err drop pulse; fill_start/fill_base/fill_count/fill_byte fill request, fill_busy,
//   fill_done pulse; vm_addr/vm_data/vm_we registered write port.
//   VMW_FILL_IRQ_EN adds fill_irq (sticky completion flag) and irq_ack.
module video_memory_writer
    import video_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [11:0] cpu_addr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_data,
    output logic        cpu_err,
    input  logic        fill_start,
    input  logic [9:0]  fill_base,
    input  logic [9:0]  fill_count,
    input  logic [7:0]  fill_byte,
    output logic        fill_busy,
    output logic        fill_done,
    output logic [9:0]  vm_addr,
    output logic [31:0] vm_data,
    output logic [3:0]  vm_we
`ifdef VMW_FILL_IRQ_EN
    ,
    output logic        fill_irq,
    input  logic        irq_ack
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    vmw_state_t state, state_nxt;
    logic [SW-1:0] starve;
    logic [9:0]  ptr, dec_addr;
    logic [10:0] fill_end, sum, end_calc;
    logic [31:0] dec_data;
    logic [3:0]  dec_we;
    logic        dec_err, accept, fill_wr, start_ok, start_empty, last, done_nxt;
    vmw_lane_decode u_dec (
        .addr(cpu_addr), .size(cpu_size), .data(cpu_data),
        .word_addr(dec_addr), .lane_data(dec_data), .we(dec_we), .err(dec_err)
    );
    // The fill range is clipped to the end of video memory; an empty range completes without writing.
    assign sum      = {1'b0, fill_base} + {1'b0, fill_count};
    assign end_calc = sum > 11'(VM_WORDS) ? 11'(VM_WORDS) : sum;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_comb begin
        start_ok    = state == IDLE && fill_start && end_calc > {1'b0, fill_base};
        start_empty = state == IDLE && fill_start && !(end_calc > {1'b0, fill_base});
        last        = fill_wr && {1'b0, ptr} == fill_end - 11'd1;
        done_nxt    = start_empty || last;
        state_nxt   = start_ok ? FILL : last ? IDLE : state;
    end
    // A pending fill forces one write after STARVE_LIMIT back-to-back CPU grants by holding cpu_ready low.
    always_comb begin
        fill_busy = state == FILL;
        cpu_ready = !(state == FILL && starve == SW'(STARVE_LIMIT));
        accept    = cpu_valid && cpu_ready;
        fill_wr   = state == FILL && !accept;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vm_addr   <= '0;
            vm_data   <= '0;
            vm_we     <= '0;
            cpu_err   <= 1'b0;
            fill_done <= 1'b0;
            starve    <= '0;
            ptr       <= '0;
            fill_end  <= '0;
        end else begin
            cpu_err   <= accept && dec_err;
            fill_done <= done_nxt;
            vm_we     <= accept ? dec_we : fill_wr ? 4'b1111 : 4'b0000;
            if (accept) begin
                vm_addr <= dec_addr;
                vm_data <= dec_data;
            end else if (fill_wr) begin
                vm_addr <= ptr;
                vm_data <= {4{fill_byte}};
            end
            if (start_ok) begin
                ptr      <= fill_base;
                fill_end <= end_calc;
            end else if (fill_wr) ptr <= ptr + 10'd1;
            starve <= fill_wr ? '0 : (accept && state == FILL) ? starve + 1'b1 : starve;
        end
`ifdef VMW_FILL_IRQ_EN
    // Setting on completion takes priority over a same-cycle acknowledge.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) fill_irq <= 1'b0;
        else        fill_irq <= done_nxt ? 1'b1 : irq_ack ? 1'b0 : fill_irq;
`endif
endmodule

// File: tb/tb_video_memory_writer.sv
// tb_video_memory_writer: directed self-checking bench for video_memory_writer
module tb_video_memory_writer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cpu_valid = 1'b0, cpu_ready, cpu_err;
    logic [11:0] cpu_addr = '0;
    logic [1:0]  cpu_size = '0;
    logic [31:0] cpu_data = '0;
    logic        fill_start = 1'b0, fill_busy, fill_done;
    logic [9:0]  fill_base = '0, fill_count = '0;
    logic [7:0]  fill_byte = '0;
    logic [9:0]  vm_addr;
    logic [31:0] vm_data;
    logic [3:0]  vm_we;
`ifdef VMW_FILL_IRQ_EN
    logic        fill_irq, irq_ack = 1'b0;
`endif
    int checks = 0, errors = 0;
    video_memory_writer #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_size(cpu_size), .cpu_data(cpu_data), .cpu_err(cpu_err),
        .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count),
        .fill_byte(fill_byte), .fill_busy(fill_busy), .fill_done(fill_done),
        .vm_addr(vm_addr), .vm_data(vm_data), .vm_we(vm_we)
`ifdef VMW_FILL_IRQ_EN
        , .fill_irq(fill_irq), .irq_ack(irq_ack)
`endif
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic store(input logic [11:0] a, input logic [1:0] s, input logic [31:0] d);
        cpu_valid = 1'b1; cpu_addr = a; cpu_size = s; cpu_data = d;
        step();
        cpu_valid = 1'b0;
    endtask
    task automatic expect_store(input string name, input logic [9:0] a, input logic [3:0] we,
                                input logic [31:0] d, input logic err);
        checks++;
        if (vm_we !== we || cpu_err !== err || (we != 4'b0000 && (vm_addr !== a || vm_data !== d))) begin
            errors++;
            $display("FAIL %s: addr=%0d we=%b data=%h err=%b, required addr=%0d we=%b data=%h err=%b",
                     name, vm_addr, vm_we, vm_data, cpu_err, a, we, d, err);
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if (vm_we !== 4'b0 || vm_addr !== 10'd0 || vm_data !== 32'd0 || cpu_err !== 1'b0 ||
            fill_busy !== 1'b0 || fill_done !== 1'b0 || cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: we=%b addr=%0d data=%h err=%b busy=%b done=%b ready=%b",
                     vm_we, vm_addr, vm_data, cpu_err, fill_busy, fill_done, cpu_ready);
        end
        rst_n = 1'b1;
        step();
    endtask
    task automatic test_cpu_store();
        store(12'd5, 2'b00, 32'h41);          expect_store("byte5", 10'd1, 4'b0010, 32'h41414141, 1'b0);
        step();                               expect_store("idle", 10'd0, 4'b0000, 32'h0, 1'b0);
        store(12'd6, 2'b01, 32'h4243);        expect_store("half6", 10'd1, 4'b1100, 32'h42434243, 1'b0);
        store(12'd1, 2'b01, 32'h4243);        expect_store("half_misalign", 10'd0, 4'b0000, 32'h0, 1'b1);
        store(12'd2400, 2'b00, 32'h41);       expect_store("byte_oor", 10'd0, 4'b0000, 32'h0, 1'b1);
        store(12'd2399, 2'b00, 32'h5A);       expect_store("byte_last", 10'd599, 4'b1000, 32'h5A5A5A5A, 1'b0);
        store(12'd8, 2'b10, 32'hDEADBEEF);    expect_store("word8", 10'd2, 4'b1111, 32'hDEADBEEF, 1'b0);
        store(12'd10, 2'b10, 32'hDEADBEEF);   expect_store("word_misalign", 10'd0, 4'b0000, 32'h0, 1'b1);
        store(12'd12, 2'b11, 32'h1);          expect_store("size_illegal", 10'd0, 4'b0000, 32'h0, 1'b1);
        step();                               expect_store("err_clear", 10'd0, 4'b0000, 32'h0, 1'b0);
    endtask
    task automatic test_fill_tail();
        int n = 0, done_at = -1;
        fill_start = 1'b1; fill_base = 10'd590; fill_count = 10'd20; fill_byte = 8'h20;
        step();
        fill_start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (vm_we != 4'b0000) begin
                checks++;
                if (vm_we !== 4'b1111 || vm_addr !== 10'(590 + n) || vm_data !== 32'h20202020) begin
                    errors++;
                    $display("FAIL fill_tail_write%0d: addr=%0d we=%b data=%h, required addr=%0d we=1111 data=20202020",
                             n, vm_addr, vm_we, vm_data, 590 + n);
                end
                n++;
            end
            if (fill_done === 1'b1) done_at = n;
        end
        checks++;
        if (n !== 10 || done_at !== 10 || fill_busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_tail_total: writes=%0d done_after=%0d busy=%b, required 10 10 0", n, done_at, fill_busy);
        end
    endtask
    task automatic test_starve();
        int nf = 0;
        bit done = 0, exp_ready;
        fill_start = 1'b1; fill_base = 10'd0; fill_count = 10'd80; fill_byte = 8'h2E;
        step();
        fill_start = 1'b0;
        cpu_valid = 1'b1; cpu_addr = 12'd2000; cpu_size = 2'b00; cpu_data = 32'h55;
        for (int k = 0; k < 450 && !done; k++) begin
            exp_ready = (k % 5) != 4;
            checks++;
            if (cpu_ready !== exp_ready) begin
                errors++;
                $display("FAIL starve_ready k=%0d: ready=%b, required %b", k, cpu_ready, exp_ready);
            end
            step();
            checks++;
            if (exp_ready) begin
                if (vm_we !== 4'b0001 || vm_addr !== 10'd500 || vm_data !== 32'h55555555) begin
                    errors++;
                    $display("FAIL starve_cpu k=%0d: addr=%0d we=%b data=%h, required 500 0001 55555555",
                             k, vm_addr, vm_we, vm_data);
                end
            end else begin
                if (vm_we !== 4'b1111 || vm_addr !== 10'(nf) || vm_data !== 32'h2E2E2E2E) begin
                    errors++;
                    $display("FAIL starve_fill k=%0d: addr=%0d we=%b data=%h, required %0d 1111 2E2E2E2E",
                             k, vm_addr, vm_we, vm_data, nf);
                end
                nf++;
            end
            if (fill_done === 1'b1) done = 1;
        end
        cpu_valid = 1'b0;
        checks++;
        if (nf !== 80 || !done || fill_busy !== 1'b0) begin
            errors++;
            $display("FAIL starve_total: fill writes=%0d done=%b busy=%b, required 80 1 0", nf, done, fill_busy);
        end
        step();
    endtask
    task automatic test_reset_mid_fill();
        bit found = 0;
        fill_start = 1'b1; fill_base = 10'd0; fill_count = 10'd600; fill_byte = 8'h11;
        step();
        fill_start = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (vm_we === 4'b1111 && vm_addr === 10'd100) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midfill_reach: word 100 not written within bound");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (vm_we !== 4'b0000 || fill_busy !== 1'b0 || vm_addr !== 10'd0) begin
            errors++;
            $display("FAIL midfill_async: we=%b busy=%b addr=%0d, required 0000 0 0", vm_we, fill_busy, vm_addr);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (fill_done !== 1'b0 || vm_we !== 4'b0000 || fill_busy !== 1'b0) begin
                errors++;
                $display("FAIL midfill_after%0d: done=%b we=%b busy=%b, required 0 0000 0", k, fill_done, vm_we, fill_busy);
            end
        end
        fill_start = 1'b1; fill_base = 10'd10; fill_count = 10'd0;
        step();
        fill_start = 1'b0;
        checks++;
        if (fill_done !== 1'b1 || vm_we !== 4'b0000 || fill_busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_fill: done=%b we=%b busy=%b, required 1 0000 0", fill_done, vm_we, fill_busy);
        end
        step();
        checks++;
        if (fill_done !== 1'b0 || vm_we !== 4'b0000) begin
            errors++;
            $display("FAIL empty_fill_pulse: done=%b we=%b, required 0 0000", fill_done, vm_we);
        end
        fill_start = 1'b1; fill_base = 10'd600; fill_count = 10'd5;
        step();
        fill_start = 1'b0;
        checks++;
        if (fill_done !== 1'b1 || vm_we !== 4'b0000 || fill_busy !== 1'b0) begin
            errors++;
            $display("FAIL base_oor_fill: done=%b we=%b busy=%b, required 1 0000 0", fill_done, vm_we, fill_busy);
        end
        step();
    endtask
`ifdef VMW_FILL_IRQ_EN
    task automatic test_irq();
        fill_start = 1'b1; fill_base = 10'd3; fill_count = 10'd1; fill_byte = 8'h30;
        step();
        fill_start = 1'b0;
        step();
        checks++;
        if (fill_done !== 1'b1 || fill_irq !== 1'b1 || vm_addr !== 10'd3) begin
            errors++;
            $display("FAIL irq_set: done=%b irq=%b addr=%0d, required 1 1 3", fill_done, fill_irq, vm_addr);
        end
        step();
        checks++;
        if (fill_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold: irq=%b, required 1", fill_irq);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        checks++;
        if (fill_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_ack: irq=%b, required 0", fill_irq);
        end
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        checks++;
        if (fill_done !== 1'b1 || fill_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins: done=%b irq=%b, required 1 1", fill_done, fill_irq);
        end
        step();
        checks++;
        if (fill_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins_hold: irq=%b, required 1", fill_irq);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask
`endif
    initial begin
        test_reset();
        test_cpu_store();
        test_fill_tail();
        test_starve();
        test_reset_mid_fill();
`ifdef VMW_FILL_IRQ_EN
        test_irq();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
